trap_csr_unit: RTL and testbench

Machine-mode trap and CSR unit that consumes the exception report produced by the pipeline controller. It commits trap state into mepc/mcause/mtval/mstatus and redirects fetch to the trap vector. It also services `mret` by restoring mstatus and redirecting fetch to mepc, and provides the CSR read/write port used by Zicsr instructions in the execute stage.

---
 rtl/trap_csr_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_trap_csr_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : trap_csr_unit
// Description : Machine-mode trap and CSR unit. Commits exception state into
//               mepc/mcause/mtval/mstatus, services mret, redirects fetch,
//               and provides the Zicsr read/write port.
//               Optional feature macro: TRAP_MTVAL_EN (implements mtval).
// Revision    : 1.0 - initial release
// ============================================================================
module trap_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_exception_i,
    input  logic [31:0] exception_program_counter_i,
    input  logic [31:0] exception_adress_i,
    input  logic [2:0]  exception_cause_i,
    input  logic        en_mret_i,
    input  logic        csr_en_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_adress_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        trap_busy_o
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [31:0] MISA_VALUE    = 32'h4000_1104;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_e;

    state_e      state_q;
    logic        redirect_valid_q;
    logic        trap_busy_q;
    logic [31:0] redirect_pc_q;

    logic        mie_q;
    logic        mpie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_val;
    logic [63:0] mcycle_q;
    logic [63:0] mcycle_d;

    logic        take_exc;
    logic        take_mret;
    logic        csr_hit;
    logic        csr_bad;
    logic        csr_wr;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic [31:0] trap_mcause;

    // Exceptions and mret are only honoured in IDLE; exception wins over mret.
    assign take_exc  = (state_q == S_IDLE) && en_exception_i;
    assign take_mret = (state_q == S_IDLE) && en_mret_i && !en_exception_i;

    // CSR read mux: current (pre-edge) architectural value of the addressed CSR.
    always_comb begin
        csr_hit = 1'b1;
        csr_old = '0;
        case (csr_adress_i)
            ADDR_MSTATUS:  csr_old = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            ADDR_MISA:     csr_old = MISA_VALUE;
            ADDR_MTVEC:    csr_old = mtvec_q;
            ADDR_MSCRATCH: csr_old = mscratch_q;
            ADDR_MEPC:     csr_old = mepc_q;
            ADDR_MCAUSE:   csr_old = mcause_q;
            ADDR_MTVAL:    csr_old = mtval_val;
            ADDR_MCYCLE:   csr_old = mcycle_q[31:0];
            ADDR_MCYCLEH:  csr_old = mcycle_q[63:32];
            default:       csr_hit = 1'b0;
        endcase
    end

    // Unimplemented address or a modifying op on read-only misa.
    assign csr_bad       = !csr_hit || ((csr_adress_i == ADDR_MISA) && (csr_op_i != 2'b00));
    assign csr_rdata_o   = csr_bad ? 32'h0 : csr_old;
    assign csr_illegal_o = csr_en_i && !en_exception_i && csr_bad;
    assign csr_wr        = csr_en_i && (state_q == S_IDLE) && !en_exception_i && !en_mret_i
                         && (csr_op_i != 2'b00) && !csr_bad;

    // Read-modify-write value selected by the Zicsr operation.
    always_comb begin
        case (csr_op_i)
            2'b01:   csr_new = csr_wdata_i;
            2'b10:   csr_new = csr_old | csr_wdata_i;
            2'b11:   csr_new = csr_old & ~csr_wdata_i;
            default: csr_new = csr_old;
        endcase
    end

    // Translate the pipeline's compact cause code into the RISC-V mcause value.
    always_comb begin
        case (exception_cause_i)
            3'd0:    trap_mcause = 32'd0;
            3'd1:    trap_mcause = 32'd2;
            3'd2:    trap_mcause = 32'd3;
            3'd3:    trap_mcause = 32'd4;
            3'd4:    trap_mcause = 32'd6;
            3'd5:    trap_mcause = 32'd11;
            default: trap_mcause = 32'd0;
        endcase
    end

    // Cycle counter: free-running increment, replaced (no increment) by a CSR write.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (csr_wr && (csr_adress_i == ADDR_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], csr_new};
        end else if (csr_wr && (csr_adress_i == ADDR_MCYCLEH)) begin
            mcycle_d = {csr_new, mcycle_q[31:0]};
        end
    end

    // Trap FSM with registered redirect outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            trap_busy_q      <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (take_exc) begin
                        state_q          <= S_REDIRECT;
                        redirect_valid_q <= 1'b1;
                        trap_busy_q      <= 1'b1;
                        redirect_pc_q    <= {mtvec_q[31:2], 2'b00};
                    end else if (take_mret) begin
                        state_q          <= S_REDIRECT;
                        redirect_valid_q <= 1'b1;
                        trap_busy_q      <= 1'b1;
                        redirect_pc_q    <= mepc_q;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q          <= S_IDLE;
                        redirect_valid_q <= 1'b0;
                        trap_busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= S_IDLE;
                    redirect_valid_q <= 1'b0;
                    trap_busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Architectural CSR state: trap commit, mret restore, or Zicsr write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
        end else begin
            mcycle_q <= mcycle_d;
            if (take_exc) begin
                mepc_q   <= {exception_program_counter_i[31:1], 1'b0};
                mcause_q <= trap_mcause;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (take_mret) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (csr_wr) begin
                case (csr_adress_i)
                    ADDR_MSTATUS: begin
                        mie_q  <= csr_new[3];
                        mpie_q <= csr_new[7];
                    end
                    ADDR_MTVEC:    mtvec_q    <= {csr_new[31:2], 2'b00};
                    ADDR_MSCRATCH: mscratch_q <= csr_new;
                    ADDR_MEPC:     mepc_q     <= {csr_new[31:1], 1'b0};
                    ADDR_MCAUSE:   mcause_q   <= csr_new;
                    default: ;
                endcase
            end
        end
    end

`ifdef TRAP_MTVAL_EN
    logic [31:0] mtval_q;
    logic [31:0] trap_mtval;

    // Faulting data address for misaligned load/store, faulting PC for fetch misalignment.
    always_comb begin
        case (exception_cause_i)
            3'd0:       trap_mtval = exception_program_counter_i;
            3'd3, 3'd4: trap_mtval = exception_adress_i;
            default:    trap_mtval = 32'h0;
        endcase
    end

    // mtval register: written by traps and by Zicsr writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtval_q <= '0;
        end else if (take_exc) begin
            mtval_q <= trap_mtval;
        end else if (csr_wr && (csr_adress_i == ADDR_MTVAL)) begin
            mtval_q <= csr_new;
        end
    end

    assign mtval_val = mtval_q;
`else
    logic unused_mtval_inputs;

    // mtval is hardwired to zero; its source operands are intentionally dropped.
    assign mtval_val           = 32'h0;
    assign unused_mtval_inputs = ^{exception_adress_i, exception_program_counter_i[0]};
`endif

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign trap_busy_o      = trap_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_csr_unit
// Description : Self-checking bench for trap_csr_unit. A CSR-map reference
//               model predicts every cycle; expectations are queued and a
//               negedge monitor compares them with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_csr_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_exception_i = 1'b0;
    logic [31:0] exception_program_counter_i = '0;
    logic [31:0] exception_adress_i = '0;
    logic [2:0]  exception_cause_i = '0;
    logic        en_mret_i = 1'b0;
    logic        csr_en_i = 1'b0;
    logic [1:0]  csr_op_i = '0;
    logic [11:0] csr_adress_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i = 1'b1;
    logic        trap_busy_o;

    always #5 clk_i = ~clk_i;

    trap_csr_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
        .clk_i                       (clk_i),
        .rst_i                       (rst_i),
        .en_exception_i              (en_exception_i),
        .exception_program_counter_i (exception_program_counter_i),
        .exception_adress_i          (exception_adress_i),
        .exception_cause_i           (exception_cause_i),
        .en_mret_i                   (en_mret_i),
        .csr_en_i                    (csr_en_i),
        .csr_op_i                    (csr_op_i),
        .csr_adress_i                (csr_adress_i),
        .csr_wdata_i                 (csr_wdata_i),
        .csr_rdata_o                 (csr_rdata_o),
        .csr_illegal_o               (csr_illegal_o),
        .redirect_valid_o            (redirect_valid_o),
        .redirect_pc_o               (redirect_pc_o),
        .redirect_ready_i            (redirect_ready_i),
        .trap_busy_o                 (trap_busy_o)
    );

    typedef struct packed {
        logic        busy;
        logic        chk_pc;
        logic [31:0] pc;
    } cyc_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        illegal;
    } csr_exp_t;

    cyc_exp_t cyc_q[$];
    csr_exp_t csr_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: CSRs kept as their architecturally visible values.
    logic [31:0] csr_m [int];
    logic [63:0] m_cycle;
    bit          m_busy;
    bit          m_known = 0;
    bit          m_pc_set;
    logic [31:0] m_pc;
    bit          hold_ready = 0;
    int unsigned cmap [6] = '{0, 2, 3, 4, 6, 11};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_exists(input logic [11:0] a);
        if (a == 12'hB00 || a == 12'hB80) return 1;
        return csr_m.exists(int'(a));
    endfunction

    function automatic logic [31:0] m_value(input logic [11:0] a);
        if (a == 12'hB00) return m_cycle[31:0];
        if (a == 12'hB80) return m_cycle[63:32];
        return csr_m[int'(a)];
    endfunction

    function automatic logic [31:0] m_legalize(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: return (v & 32'h0000_0088) | 32'h0000_1800;
            12'h305: return v & ~32'h3;
            12'h341: return v & ~32'h1;
`ifdef TRAP_MTVAL_EN
            12'h343: return v;
`else
            12'h343: return 32'h0;
`endif
            default: return v;
        endcase
    endfunction

    task automatic m_reset();
        csr_m.delete();
        csr_m['h300] = 32'h0000_1800;
        csr_m['h301] = 32'h4000_1104;
        csr_m['h305] = 32'h0000_0100;
        csr_m['h340] = 0;
        csr_m['h341] = 0;
        csr_m['h342] = 0;
        csr_m['h343] = 0;
        m_cycle  = 0;
        m_busy   = 0;
        m_pc     = 0;
        m_pc_set = 0;
        m_known  = 1;
    endtask

    // Advance the model across one rising edge using the inputs of this cycle.
    task automatic m_edge();
        logic [31:0] old, nv, st;
        logic [63:0] nc;
        if (!rst_i) begin
            m_reset();
            return;
        end
        if (!m_known) return;
        nc = m_cycle + 64'd1;
        if (!m_busy) begin
            if (en_exception_i) begin
                st = csr_m['h300];
                csr_m['h341] = exception_program_counter_i & ~32'h1;
                csr_m['h342] = cmap[exception_cause_i];
                if (exception_cause_i == 3 || exception_cause_i == 4)
                    csr_m['h343] = m_legalize(12'h343, exception_adress_i);
                else if (exception_cause_i == 0)
                    csr_m['h343] = m_legalize(12'h343, exception_program_counter_i);
                else
                    csr_m['h343] = 0;
                csr_m['h300] = 32'h1800 | (st[3] ? 32'h80 : 32'h0);
                m_busy = 1; m_pc = csr_m['h305]; m_pc_set = 1;
            end else if (en_mret_i) begin
                st = csr_m['h300];
                csr_m['h300] = 32'h1880 | (st[7] ? 32'h8 : 32'h0);
                m_busy = 1; m_pc = csr_m['h341]; m_pc_set = 1;
            end else if (csr_en_i && csr_op_i != 0 && m_exists(csr_adress_i)
                         && csr_adress_i != 12'h301) begin
                old = m_value(csr_adress_i);
                nv  = (csr_op_i == 1) ? csr_wdata_i :
                      (csr_op_i == 2) ? (old | csr_wdata_i) : (old & ~csr_wdata_i);
                if (csr_adress_i == 12'hB00)      nc = {m_cycle[63:32], nv};
                else if (csr_adress_i == 12'hB80) nc = {nv, m_cycle[31:0]};
                else csr_m[int'(csr_adress_i)] = m_legalize(csr_adress_i, nv);
            end
        end else if (redirect_ready_i) begin
            m_busy = 0;
        end
        m_cycle = nc;
    endtask

    // Queue this cycle's expectations, then let the clock edge happen.
    task automatic tick();
        cyc_exp_t ec;
        csr_exp_t cc;
        bit bad;
        if (m_known) begin
            ec.busy   = m_busy;
            ec.chk_pc = m_busy || !m_pc_set;
            ec.pc     = m_pc;
            cyc_q.push_back(ec);
            if (csr_en_i) begin
                bad = !m_exists(csr_adress_i) || (csr_adress_i == 12'h301 && csr_op_i != 0);
                cc.rdata   = bad ? 32'h0 : m_value(csr_adress_i);
                cc.illegal = bad && !en_exception_i;
                csr_q.push_back(cc);
            end
        end
        @(posedge clk_i);
        m_edge();
        #1;
    endtask

    // Monitor: compare DUT outputs against queued expectations mid-cycle.
    always @(negedge clk_i) begin : monitor
        cyc_exp_t ec;
        csr_exp_t cc;
        if (cyc_q.size() > 0) begin
            ec = cyc_q.pop_front();
            chk("trap_busy", 32'(trap_busy_o), 32'(ec.busy));
            chk("redirect_valid", 32'(redirect_valid_o), 32'(ec.busy));
            if (ec.chk_pc) chk("redirect_pc", redirect_pc_o, ec.pc);
        end
        if (csr_en_i && csr_q.size() > 0) begin
            cc = csr_q.pop_front();
            chk("csr_rdata", csr_rdata_o, cc.rdata);
            chk("csr_illegal", 32'(csr_illegal_o), 32'(cc.illegal));
        end
    end

    task automatic clr();
        rst_i = 1; en_exception_i = 0; en_mret_i = 0; csr_en_i = 0;
        csr_op_i = 0; csr_adress_i = 0; csr_wdata_i = 0;
        exception_program_counter_i = 0; exception_adress_i = 0; exception_cause_i = 0;
        redirect_ready_i = !hold_ready;
    endtask

    task automatic rd(input logic [11:0] a);
        clr(); csr_en_i = 1; csr_op_i = 2'b00; csr_adress_i = a; tick();
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
        clr(); csr_en_i = 1; csr_op_i = op; csr_adress_i = a; csr_wdata_i = w; tick();
    endtask

    task automatic exc(input logic [31:0] pc, input logic [31:0] ad, input logic [2:0] code);
        clr(); en_exception_i = 1; exception_program_counter_i = pc;
        exception_adress_i = ad; exception_cause_i = code; tick();
    endtask

    logic [11:0] addrs [10] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'hB00, 12'hB80, 12'h7C0};

    initial begin
        int idx;
        clr(); rst_i = 0; tick(); tick();
        foreach (addrs[i]) rd(addrs[i]);

        // Load misaligned, redirect held for several cycles.
        exc(32'h0000_0204, 32'h0000_1003, 3'd3);
        hold_ready = 1;
        rd(12'h342); rd(12'h341); rd(12'h343); rd(12'h300);
        hold_ready = 0;
        clr(); tick(); clr(); tick();

        // Enable MIE, ecall, then mret.
        wr(2'b10, 12'h300, 32'h8);
        rd(12'h300);
        exc(32'h0000_0303, 32'h0, 3'd5);
        clr(); tick();
        rd(12'h342); rd(12'h341); rd(12'h300);
        clr(); en_mret_i = 1; tick();
        clr(); tick();
        rd(12'h300);

        // Exception + mret + mscratch write in one cycle: only the trap happens.
        wr(2'b01, 12'h340, 32'hDEAD_BEEF);
        clr(); en_exception_i = 1; exception_program_counter_i = 32'h400;
        exception_cause_i = 3'd1; en_mret_i = 1; csr_en_i = 1; csr_op_i = 2'b01;
        csr_adress_i = 12'h340; csr_wdata_i = 32'h1234; tick();
        clr(); tick();
        rd(12'h340); rd(12'h342);

        // mtvec alignment, read-only misa, unimplemented address.
        wr(2'b01, 12'h305, 32'h0000_2003);
        rd(12'h305);
        wr(2'b01, 12'h301, 32'h5);
        rd(12'h301);
        rd(12'h7C0);
        exc(32'h0000_0500, 32'h0, 3'd2);
        clr(); tick();

        // mcycle wrap, then reset in the middle of a redirect.
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        rd(12'hB00); rd(12'hB80); rd(12'hB00);
        exc(32'h0000_0600, 32'h0000_0777, 3'd4);
        hold_ready = 1;
        clr(); rst_i = 0; tick();
        hold_ready = 0;
        clr(); tick();
        rd(12'h305); rd(12'h300);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            clr();
            rst_i = ($urandom_range(0, 149) != 0);
            en_exception_i = ($urandom_range(0, 7) == 0);
            exception_program_counter_i = $urandom;
            exception_adress_i = $urandom;
            exception_cause_i = 3'($urandom_range(0, 5));
            en_mret_i = ($urandom_range(0, 7) == 0);
            redirect_ready_i = ($urandom_range(0, 2) != 0);
            csr_en_i = 1'($urandom_range(0, 1));
            csr_op_i = 2'($urandom_range(0, 3));
            idx = $urandom_range(0, 10);
            csr_adress_i = (idx == 10) ? 12'($urandom) : addrs[idx];
            csr_wdata_i = $urandom;
            if (en_exception_i && (!m_exists(csr_adress_i) || csr_adress_i == 12'h301))
                csr_en_i = 0;
            tick();
        end

        clr(); tick();
        @(negedge clk_i);
        #1;
        chk("queues_drained", 32'(cyc_q.size() + csr_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
